memory_dma: RTL and testbench

//  Bus initiator for the memory_bus address/data/write_enable interface; copies or fills a block of bytes.

---
 rtl/memory_dma_pkg.sv | 34 +++
 rtl/dma_wait_counter.sv | 25 ++
 rtl/memory_dma.sv | 187 ++++++++++++++++++
 tb/tb_memory_dma.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_dma_pkg.sv
// rtl/memory_dma_pkg.sv - state encodings, memory map and address helper shared by memory_dma
package memory_dma_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_RD   = 3'd2;
   localparam logic [2:0] ST_WR   = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;
   localparam logic [2:0] ST_NEXT = 3'd5;
   localparam logic [2:0] ST_DONE = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_RD   = ST_RD,
      S_WR   = ST_WR,
      S_HOLD = ST_HOLD,
      S_NEXT = ST_NEXT,
      S_DONE = ST_DONE
   } dma_state_t;

   localparam logic [15:0] RAM_BASE    = 16'h0000;
   localparam logic [15:0] ROM_BASE    = 16'h4000;
   localparam logic [15:0] PERIPH_BASE = 16'h8000;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   // Forward-only stepping; 16'hFFFF rolls over to 16'h0000 by design.
   function automatic logic [15:0] addr_step(input logic [15:0] a);
      return a + 16'd1;
   endfunction

endpackage

// File: rtl/dma_wait_counter.sv
// rtl/dma_wait_counter.sv - 3-bit read-latency down-counter; expire marks the data-capture cycle
module dma_wait_counter (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_load,
   input  logic [2:0] i_load_val,
   input  logic       i_en,
   output logic       o_expire
);

   logic [2:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 3'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != 3'd0)) begin
         r_count <= r_count - 3'd1;
      end
   end

   assign o_expire = (r_count == 3'd0);

endmodule

// File: rtl/memory_dma.sv
// rtl/memory_dma.sv - byte-serial copy/fill bus initiator for the memory_bus interface
// All bus-facing outputs are registered from the next-state decode so they change only on clk.
module memory_dma
   import memory_dma_pkg::*;
#(
   parameter int READ_WAIT = 2,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 mode,
   input  logic [15:0]          src_addr,
   input  logic [15:0]          dst_addr,
   input  logic [LEN_WIDTH-1:0] length,
   input  logic [7:0]           fill_value,
   input  logic                 abort,
   input  logic                 bus_grant,
   input  logic [7:0]           bus_data_in,
   output logic                 bus_request,
   output logic [15:0]          bus_address,
   output logic [7:0]           bus_data_out,
   output logic                 bus_write_enable,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted
);

   localparam logic [2:0] LP_WAIT_LOAD = 3'(READ_WAIT - 1);

   dma_state_t           r_state;
   logic                 r_mode;
   logic [15:0]          r_src;
   logic [15:0]          r_dst;
   logic [LEN_WIDTH-1:0] r_count;
   logic [7:0]           r_data;
   logic                 r_bus_req;
   logic [15:0]          r_bus_addr;
   logic [7:0]           r_bus_dout;
   logic                 r_bus_we;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_aborted;

   dma_state_t           w_state_nxt;
   dma_state_t           w_xfer_state;
   logic                 w_set_abort;
   logic                 w_accept;
   logic [15:0]          w_src_nxt;
   logic [15:0]          w_dst_nxt;
   logic [LEN_WIDTH-1:0] w_cnt_nxt;
   logic [7:0]           w_data_nxt;
   logic                 w_wait_load;
   logic                 w_wait_en;
   logic                 w_expire;

   dma_wait_counter u_wait (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_load     (w_wait_load),
      .i_load_val (LP_WAIT_LOAD),
      .i_en       (w_wait_en),
      .o_expire   (w_expire)
   );

   assign w_accept     = (r_state == S_IDLE) && start;
   assign w_xfer_state = (r_mode == MODE_FILL) ? S_WR : S_RD;

   // Pointer and count advances happen only on the NEXT cycle; the bus registers pick up the advanced values.
   assign w_src_nxt  = ((r_state == S_NEXT) && (r_mode == MODE_COPY)) ? addr_step(r_src) : r_src;
   assign w_dst_nxt  = (r_state == S_NEXT) ? addr_step(r_dst) : r_dst;
   assign w_cnt_nxt  = (r_state == S_NEXT) ? (r_count - LEN_WIDTH'(1)) : r_count;
   assign w_data_nxt = ((r_state == S_RD) && w_expire) ? bus_data_in : r_data;

   assign w_wait_load = (w_state_nxt == S_RD) && (r_state != S_RD);
   assign w_wait_en   = (r_state == S_RD);

   always_comb begin
      w_state_nxt = r_state;
      w_set_abort = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = (length == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (abort) begin
               w_state_nxt = S_DONE;
               w_set_abort = 1'b1;
            end else if (bus_grant) begin
               w_state_nxt = w_xfer_state;
            end
         end
         S_RD: begin
            if (w_expire) begin
               w_state_nxt = S_WR;
            end
         end
         S_WR:   w_state_nxt = S_HOLD;
         S_HOLD: w_state_nxt = S_NEXT;
         S_NEXT: begin
            // Grant loss is honoured only here, so a started byte always finishes.
            if (w_cnt_nxt == '0) begin
               w_state_nxt = S_DONE;
            end else if (abort) begin
               w_state_nxt = S_DONE;
               w_set_abort = 1'b1;
            end else if (!bus_grant) begin
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = w_xfer_state;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_mode     <= 1'b0;
         r_src      <= 16'h0000;
         r_dst      <= 16'h0000;
         r_count    <= '0;
         r_data     <= 8'h00;
         r_bus_req  <= 1'b0;
         r_bus_addr <= 16'h0000;
         r_bus_dout <= 8'h00;
         r_bus_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_aborted  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_accept) begin
            r_mode    <= mode;
            r_src     <= src_addr;
            r_dst     <= dst_addr;
            r_count   <= length;
            r_data    <= fill_value;
            r_aborted <= 1'b0;
         end else begin
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_count <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            if (w_set_abort) begin
               r_aborted <= 1'b1;
            end
         end

         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         r_bus_req <= (w_state_nxt == S_REQ) || (w_state_nxt == S_RD) || (w_state_nxt == S_WR) ||
                      (w_state_nxt == S_HOLD) || (w_state_nxt == S_NEXT);
         r_bus_we  <= (w_state_nxt == S_WR);

         // HOLD repeats the WR address/data because memory_bus samples the strobe a cycle late.
         case (w_state_nxt)
            S_RD: begin
               r_bus_addr <= w_src_nxt;
               r_bus_dout <= 8'h00;
            end
            S_WR, S_HOLD: begin
               r_bus_addr <= w_dst_nxt;
               r_bus_dout <= w_data_nxt;
            end
            default: begin
               r_bus_addr <= 16'h0000;
               r_bus_dout <= 8'h00;
            end
         endcase
      end
   end

   assign bus_request      = r_bus_req;
   assign bus_address      = r_bus_addr;
   assign bus_data_out     = r_bus_dout;
   assign bus_write_enable = r_bus_we;
   assign busy             = r_busy;
   assign done             = r_done;
   assign aborted          = r_aborted;

endmodule

// File: tb/tb_memory_dma.sv
// tb/tb_memory_dma.sv - memory_dma against a memory_bus model, a grant stub and a byte-array reference
`timescale 1ns/1ps
module tb_memory_dma;

   localparam int RW     = 2;
   localparam int LW     = 16;
   localparam int RD_TAP = (RW > 1) ? RW - 2 : 0;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [15:0]   src_addr = 16'h0;
   logic [15:0]   dst_addr = 16'h0;
   logic [LW-1:0] length = '0;
   logic [7:0]    fill_value = 8'h0;
   logic          abort = 1'b0;
   logic          bus_grant = 1'b0;
   logic [7:0]    bus_data_in;
   logic          bus_request;
   logic [15:0]   bus_address;
   logic [7:0]    bus_data_out;
   logic          bus_write_enable;
   logic          busy;
   logic          done;
   logic          aborted;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  exp_mem [0:65535];
   logic        pl_en = 1'b0;
   logic [15:0] pl_addr = 16'h0;
   logic [7:0]  pl_data = 8'h0;
   logic        we_q = 1'b0;
   logic [15:0] wa_q = 16'h0;
   logic [7:0]  wd_q = 8'h0;
   logic [15:0] ra_pipe [0:6];

   int          done_cnt = 0;
   int          req_cycles = 0;
   int          hold_viol = 0;
   logic [15:0] wr_addrs [$];
   logic        prev_we = 1'b0;
   logic [15:0] prev_addr = 16'h0;
   logic [7:0]  prev_dout = 8'h0;

   int done_base, wr_base, req_base, hold_base;

   memory_dma #(.READ_WAIT(RW), .LEN_WIDTH(LW)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .mode             (mode),
      .src_addr         (src_addr),
      .dst_addr         (dst_addr),
      .length           (length),
      .fill_value       (fill_value),
      .abort            (abort),
      .bus_grant        (bus_grant),
      .bus_data_in      (bus_data_in),
      .bus_request      (bus_request),
      .bus_address      (bus_address),
      .bus_data_out     (bus_data_out),
      .bus_write_enable (bus_write_enable),
      .busy             (busy),
      .done             (done),
      .aborted          (aborted)
   );

   always #5 clk = ~clk;

   // memory_bus model: write strobe registered one cycle, read data RW cycles after address.
   always @(posedge clk) begin
      we_q <= bus_write_enable;
      wa_q <= bus_address;
      wd_q <= bus_data_out;
      if (we_q) mem[wa_q] <= wd_q;
      if (pl_en) mem[pl_addr] <= pl_data;
      ra_pipe[0] <= bus_address;
      for (int i = 1; i < 7; i++) ra_pipe[i] <= ra_pipe[i-1];
   end

   assign bus_data_in = (RW == 1) ? mem[bus_address] : mem[ra_pipe[RD_TAP]];

   always @(negedge clk) begin
      if (!reset) begin
         prev_we = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (bus_request) req_cycles++;
         if (prev_we && (bus_write_enable || bus_address !== prev_addr || bus_data_out !== prev_dout))
            hold_viol++;
         if (bus_write_enable) wr_addrs.push_back(bus_address);
         prev_we   = bus_write_enable;
         prev_addr = bus_address;
         prev_dout = bus_data_out;
      end
   end

   task automatic preload(input logic [15:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pl_en   = 1'b1;
         pl_addr = base + 16'(i);
         pl_data = 8'($urandom);
         exp_mem[pl_addr] = pl_data;
      end
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      exp_mem[a] = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic model_xfer(input logic m, input logic [15:0] s, input logic [15:0] d, input int n,
                             input logic [7:0] f);
      logic [15:0] sa, da;
      for (int i = 0; i < n; i++) begin
         sa = s + 16'(i);
         da = d + 16'(i);
         exp_mem[da] = m ? f : exp_mem[sa];
      end
   endtask

   task automatic start_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                             input logic [LW-1:0] n, input logic [7:0] f);
      @(negedge clk);
      mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
      start = 1'b1;
      done_base = done_cnt;
      wr_base   = wr_addrs.size();
      req_base  = req_cycles;
      hold_base = hold_viol;
   endtask

   // cyc counts the start cycle and the done cycle inclusively; -1 on timeout.
   task automatic wait_done(output int cyc);
      int w;
      bit seen;
      w = 0; seen = 1'b0;
      while (!seen && w < 2000) begin
         @(negedge clk);
         start = 1'b0;
         w++;
         if (done) seen = 1'b1;
      end
      cyc = seen ? w + 1 : -1;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL done_timeout: no done within %0d cycles, required done pulse", w);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus_request, bus_address, bus_data_out, bus_write_enable, busy, done, aborted} !== 29'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h required 0",
                  {bus_request, bus_address, bus_data_out, bus_write_enable, busy, done, aborted});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus_request !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: req=%b busy=%b done=%b required 0 0 0", bus_request, busy, done);
      end
   endtask

   task automatic test_copy();
      logic [7:0] pat [4];
      int cyc, mism;
      pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      preload(16'h0000, 160);
      for (int i = 0; i < 4; i++) poke(16'h0010 + 16'(i), pat[i]);
      bus_grant = 1'b1;
      start_xfer(1'b0, 16'h0010, 16'h0080, 4, 8'h00);
      wait_done(cyc);
      model_xfer(1'b0, 16'h0010, 16'h0080, 4, 8'h00);
      checks++;
      if (cyc !== 4 * (RW + 3) + 3) begin
         errors++; $display("FAIL copy_cycles: got %0d required %0d", cyc, 4 * (RW + 3) + 3);
      end
      checks++;
      if (done_cnt - done_base !== 1) begin
         errors++; $display("FAIL copy_done_count: got %0d required 1", done_cnt - done_base);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[16'h0080 + 16'(i)] !== pat[i]) begin
            errors++; $display("FAIL copy_byte%0d: got %h required %h", i, mem[16'h0080 + 16'(i)], pat[i]);
         end
      end
      mism = 0;
      for (int i = 0; i < 160; i++) if (mem[16'(i)] !== exp_mem[16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL copy_region: %0d bytes differ, required 0", mism);
      end
      checks++;
      if (aborted !== 1'b0 || busy !== 1'b0 || bus_request !== 1'b0) begin
         errors++; $display("FAIL copy_end_state: aborted=%b busy=%b req=%b required 0 0 0", aborted, busy, bus_request);
      end
   endtask

   task automatic test_fill();
      int cyc, mism;
      preload(16'h00F8, 24);
      start_xfer(1'b1, 16'h0000, 16'h0100, 3, 8'h5A);
      wait_done(cyc);
      model_xfer(1'b1, 16'h0000, 16'h0100, 3, 8'h5A);
      checks++;
      if (cyc !== 12) begin
         errors++; $display("FAIL fill_cycles: got %0d required 12", cyc);
      end
      checks++;
      if (wr_addrs.size() - wr_base !== 3) begin
         errors++; $display("FAIL fill_we_pulses: got %0d required 3", wr_addrs.size() - wr_base);
      end
      checks++;
      if (hold_viol - hold_base !== 0) begin
         errors++; $display("FAIL fill_hold: got %0d bad hold cycles required 0", hold_viol - hold_base);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[16'h0100 + 16'(i)] !== 8'h5A) begin
            errors++; $display("FAIL fill_byte%0d: got %h required 5a", i, mem[16'h0100 + 16'(i)]);
         end
      end
      mism = 0;
      for (int i = 0; i < 24; i++) if (mem[16'h00F8 + 16'(i)] !== exp_mem[16'h00F8 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL fill_region: %0d bytes differ, required 0", mism);
      end
   endtask

   task automatic test_zero_length();
      int cyc, mism;
      preload(16'h0300, 16);
      start_xfer(1'b0, 16'h0300, 16'h0308, 0, 8'h00);
      wait_done(cyc);
      checks++;
      if (cyc !== 2) begin
         errors++; $display("FAIL zero_cycles: got %0d required 2", cyc);
      end
      checks++;
      if (req_cycles - req_base !== 0 || wr_addrs.size() - wr_base !== 0) begin
         errors++; $display("FAIL zero_bus_activity: req_cycles=%0d writes=%0d required 0 0",
                            req_cycles - req_base, wr_addrs.size() - wr_base);
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (mem[16'h0300 + 16'(i)] !== exp_mem[16'h0300 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL zero_region: %0d bytes differ, required 0", mism);
      end
   endtask

   task automatic test_grant_pause();
      int cyc, mism, bad, w;
      preload(16'h0400, 48);
      bus_grant = 1'b1;
      start_xfer(1'b0, 16'h0400, 16'h0420, 3, 8'h00);
      w = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         w++;
      end while (!bus_write_enable && w < 100);
      bus_grant = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i >= 2 && (bus_request !== 1'b1 || bus_address !== 16'h0 || bus_data_out !== 8'h0 ||
                        bus_write_enable !== 1'b0 || busy !== 1'b1)) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL pause_outputs: %0d bad paused cycles required 0 (req=%b addr=%h we=%b)",
                            bad, bus_request, bus_address, bus_write_enable);
      end
      checks++;
      if (mem[16'h0420] !== exp_mem[16'h0400] || wr_addrs.size() - wr_base !== 1) begin
         errors++; $display("FAIL pause_first_byte: got %h writes=%0d required %h writes=1",
                            mem[16'h0420], wr_addrs.size() - wr_base, exp_mem[16'h0400]);
      end
      bus_grant = 1'b1;
      wait_done(cyc);
      model_xfer(1'b0, 16'h0400, 16'h0420, 3, 8'h00);
      checks++;
      if (wr_addrs.size() - wr_base !== 3 || done_cnt - done_base !== 1) begin
         errors++; $display("FAIL pause_resume: writes=%0d dones=%0d required 3 1",
                            wr_addrs.size() - wr_base, done_cnt - done_base);
      end
      mism = 0;
      for (int i = 0; i < 48; i++) if (mem[16'h0400 + 16'(i)] !== exp_mem[16'h0400 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL pause_region: %0d bytes differ, required 0", mism);
      end
   endtask

   task automatic test_abort();
      int cyc, mism, k, w;
      logic [7:0] f;
      f = 8'($urandom);
      preload(16'h0500, 32);
      bus_grant = 1'b1;
      start_xfer(1'b1, 16'h0000, 16'h0500, 8, f);
      k = 0; w = 0;
      while (k < 3 && w < 200) begin
         @(negedge clk);
         start = 1'b0;
         w++;
         if (bus_write_enable) k++;
      end
      abort = 1'b1;
      wait_done(cyc);
      abort = 1'b0;
      model_xfer(1'b1, 16'h0000, 16'h0500, 3, f);
      checks++;
      if (aborted !== 1'b1 || done_cnt - done_base !== 1) begin
         errors++; $display("FAIL abort_flags: aborted=%b dones=%0d required 1 1", aborted, done_cnt - done_base);
      end
      checks++;
      if (wr_addrs.size() - wr_base !== 3) begin
         errors++; $display("FAIL abort_writes: got %0d required 3", wr_addrs.size() - wr_base);
      end
      mism = 0;
      for (int i = 0; i < 32; i++) if (mem[16'h0500 + 16'(i)] !== exp_mem[16'h0500 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL abort_region: %0d bytes differ, required 0", mism);
      end
      // start with abort already high: accepted, then ends from REQ with no bytes
      abort = 1'b1;
      start_xfer(1'b1, 16'h0000, 16'h0510, 2, f);
      wait_done(cyc);
      abort = 1'b0;
      checks++;
      if (cyc !== 3 || wr_addrs.size() - wr_base !== 0 || aborted !== 1'b1) begin
         errors++; $display("FAIL abort_in_req: cycles=%0d writes=%0d aborted=%b required 3 0 1",
                            cyc, wr_addrs.size() - wr_base, aborted);
      end
      start_xfer(1'b0, 16'h0000, 16'h0000, 0, 8'h00);
      wait_done(cyc);
      checks++;
      if (aborted !== 1'b0) begin
         errors++; $display("FAIL abort_clear: got %b required 0", aborted);
      end
   endtask

   task automatic test_reset_wrap();
      int cyc, mism, w;
      logic [7:0] f;
      preload(16'h0600, 8);
      bus_grant = 1'b1;
      start_xfer(1'b1, 16'h0000, 16'h0600, 4, 8'h33);
      w = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         w++;
      end while (!bus_write_enable && w < 100);
      reset = 1'b0;
      #1;
      checks++;
      if ({bus_request, bus_address, bus_data_out, bus_write_enable, busy, done, aborted} !== 29'h0) begin
         errors++;
         $display("FAIL reset_mid_wr: got %h required 0",
                  {bus_request, bus_address, bus_data_out, bus_write_enable, busy, done, aborted});
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      f = 8'($urandom);
      preload(16'hFFF8, 16);
      start_xfer(1'b1, 16'h0000, 16'hFFFF, 2, f);
      wait_done(cyc);
      model_xfer(1'b1, 16'h0000, 16'hFFFF, 2, f);
      checks++;
      if (cyc !== 9) begin
         errors++; $display("FAIL wrap_cycles: got %0d required 9", cyc);
      end
      checks++;
      if (wr_addrs.size() - wr_base !== 2) begin
         errors++; $display("FAIL wrap_writes: got %0d required 2", wr_addrs.size() - wr_base);
      end else begin
         checks++;
         if (wr_addrs[wr_base] !== 16'hFFFF || wr_addrs[wr_base+1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_addrs: got %h %h required ffff 0000",
                               wr_addrs[wr_base], wr_addrs[wr_base+1]);
         end
      end
      mism = 0;
      for (int i = 0; i < 16; i++) if (mem[16'hFFF8 + 16'(i)] !== exp_mem[16'hFFF8 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin
         errors++; $display("FAIL wrap_region: %0d bytes differ, required 0", mism);
      end
   endtask

   task automatic test_random();
      int cyc, mism, so, dof, n, ecyc;
      logic m;
      logic [7:0] f;
      bus_grant = 1'b1;
      for (int it = 0; it < 8; it++) begin
         preload(16'h0800, 64);
         m   = (it == 0) ? 1'b0 : 1'($urandom);
         so  = $urandom_range(0, 24);
         dof = (it == 0) ? so + 1 : $urandom_range(0, 24);
         n   = (it == 1) ? 0 : $urandom_range(1, 12);
         f   = 8'($urandom);
         start_xfer(m, 16'h0800 + 16'(so), 16'h0800 + 16'(dof), LW'(n), f);
         wait_done(cyc);
         model_xfer(m, 16'h0800 + 16'(so), 16'h0800 + 16'(dof), n, f);
         ecyc = (n == 0) ? 2 : n * (m ? 3 : RW + 3) + 3;
         checks++;
         if (cyc !== ecyc) begin
            errors++; $display("FAIL rand%0d_cycles: got %0d required %0d", it, cyc, ecyc);
         end
         checks++;
         if (wr_addrs.size() - wr_base !== n || done_cnt - done_base !== 1) begin
            errors++; $display("FAIL rand%0d_counts: writes=%0d dones=%0d required %0d 1",
                               it, wr_addrs.size() - wr_base, done_cnt - done_base, n);
         end
         mism = 0;
         for (int i = 0; i < 64; i++) if (mem[16'h0800 + 16'(i)] !== exp_mem[16'h0800 + 16'(i)]) mism++;
         checks++;
         if (mism != 0) begin
            errors++; $display("FAIL rand%0d_region: %0d bytes differ, required 0 (mode=%b src+%0d dst+%0d len=%0d)",
                               it, mism, m, so, dof, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_fill();
      test_zero_length();
      test_grant_pause();
      test_abort();
      test_reset_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
